// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and Zicsr / ECALL / EBREAK / MRET executor.
// Latency: a CSR op produces its result 1 cycle after accept. A trap or return
//   spends one cycle in TRAP/RET, then presents its redirect.
// Backpressure: result registers hold while o_valid & ~i_ready. o_ready is low
//   outside IDLE and while a result is stalled.
// Ports: i_clk/i_rst        clock, async active-high reset
//        i_valid/o_ready    request handshake from IDU (func3, sysop, csrid, rs1, rd, pc)
//        o_valid/i_ready    result handshake to WBU (rdid, rdwen, rdval, redirect, illegal)
module csr_unit #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter logic [XLEN-1:0] HARTID    = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_func3,
  input  logic [1:0]      i_sysop,
  input  logic [11:0]     i_csrid,
  input  logic [4:0]      i_rs1id,
  input  logic [XLEN-1:0] i_rs1val,
  input  logic [4:0]      i_rdid,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [4:0]      o_rdid,
  output logic            o_rdwen,
  output logic [XLEN-1:0] o_rdval,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_illegal
);

  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_RET, S_WAIT} state_t;

  state_t          r_state;
  logic            r_mie, r_mpie;
  logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mcycle;
  logic [XLEN-1:0] r_trap_pc;
  logic            r_trap_ebreak;

  logic            r_valid, r_rdwen, r_redirect, r_illegal;
  logic [4:0]      r_rdid;
  logic [XLEN-1:0] r_rdval, r_redirect_pc;

  logic            w_is_sys, w_is_csr, w_op_rw, w_op_rs;
  logic            w_read_en, w_write_en, w_mapped, w_illegal, w_accept, w_csr_wr;
  logic [XLEN-1:0] w_src, w_old, w_new, w_mstatus;

  // mstatus view: MPP (12:11) hardwired to M-mode, MPIE bit 7, MIE bit 3.
  assign w_mstatus = XLEN'({2'b11, 3'b000, r_mpie, 3'b000, r_mie, 3'b000});

  assign w_is_sys   = (i_func3 == 3'b000);
  assign w_is_csr   = (i_func3[1:0] != 2'b00);
  assign w_op_rw    = (i_func3[1:0] == 2'b01);
  assign w_op_rs    = (i_func3[1:0] == 2'b10);
  assign w_src      = i_func3[2] ? XLEN'(i_rs1id) : i_rs1val;
  assign w_read_en  = w_is_csr & (~w_op_rw | (i_rdid != 5'd0));
  assign w_write_en = w_is_csr & (w_op_rw | (i_rs1id != 5'd0));

  always_comb begin
    w_mapped = 1'b1;
    w_old    = '0;
    case (i_csrid)
      12'h300: w_old = w_mstatus;
      12'h305: w_old = r_mtvec;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'hB00: w_old = r_mcycle;
      12'hF14: w_old = HARTID;
      default: w_mapped = 1'b0;
    endcase
  end

  assign w_new = w_op_rw ? w_src : (w_op_rs ? (w_old | w_src) : (w_old & ~w_src));

  assign w_illegal = (i_func3 == 3'b100)
                   | (w_is_sys & (i_sysop == 2'b00))
                   | (w_is_csr & ~w_mapped & (w_read_en | w_write_en))
                   | (w_is_csr & w_write_en & (i_csrid[11:10] == 2'b11));

  assign o_ready  = (r_state == S_IDLE) & (~r_valid | i_ready);
  assign w_accept = i_valid & o_ready;
  assign w_csr_wr = w_accept & w_is_csr & w_write_en & ~w_illegal;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_mie         <= 1'b0;
      r_mpie        <= 1'b0;
      r_mtvec       <= MTVEC_RST;
      r_mscratch    <= '0;
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_mcycle      <= '0;
      r_trap_pc     <= '0;
      r_trap_ebreak <= 1'b0;
      r_valid       <= 1'b0;
      r_rdwen       <= 1'b0;
      r_redirect    <= 1'b0;
      r_illegal     <= 1'b0;
      r_rdid        <= '0;
      r_rdval       <= '0;
      r_redirect_pc <= '0;
    end else begin
      // A software write to mcycle replaces this cycle's increment.
      if (w_csr_wr && (i_csrid == 12'hB00)) r_mcycle <= w_new;
      else                                  r_mcycle <= r_mcycle + XLEN'(1);

      if (w_csr_wr) begin
        case (i_csrid)
          12'h300: begin
            r_mie  <= w_new[3];
            r_mpie <= w_new[7];
          end
          12'h305: r_mtvec    <= {w_new[XLEN-1:2], 2'b00};
          12'h340: r_mscratch <= w_new;
          12'h341: r_mepc     <= {w_new[XLEN-1:2], 2'b00};
          12'h342: r_mcause   <= w_new;
          default: ;
        endcase
      end

      if (r_valid && i_ready) r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rdid <= i_rdid;
            if (w_is_sys && !w_illegal) begin
              r_trap_pc     <= i_pc;
              r_trap_ebreak <= (i_sysop == 2'b10);
              r_state       <= (i_sysop == 2'b11) ? S_RET : S_TRAP;
            end else begin
              r_valid       <= 1'b1;
              r_rdwen       <= ~w_illegal & w_read_en & (i_rdid != 5'd0);
              r_rdval       <= w_illegal ? '0 : w_old;
              r_redirect    <= 1'b0;
              r_redirect_pc <= '0;
              r_illegal     <= w_illegal;
            end
          end
        end
        S_TRAP: begin
          r_mepc        <= {r_trap_pc[XLEN-1:2], 2'b00};
          r_mcause      <= r_trap_ebreak ? XLEN'(3) : XLEN'(11);
          r_mpie        <= r_mie;
          r_mie         <= 1'b0;
          r_valid       <= 1'b1;
          r_rdwen       <= 1'b0;
          r_rdval       <= '0;
          r_redirect    <= 1'b1;
          r_redirect_pc <= r_mtvec;
          r_illegal     <= 1'b0;
          r_state       <= S_WAIT;
        end
        S_RET: begin
          r_mie         <= r_mpie;
          r_mpie        <= 1'b1;
          r_valid       <= 1'b1;
          r_rdwen       <= 1'b0;
          r_rdval       <= '0;
          r_redirect    <= 1'b1;
          r_redirect_pc <= r_mepc;
          r_illegal     <= 1'b0;
          r_state       <= S_WAIT;
        end
        S_WAIT: begin
          if (r_valid && i_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_valid       = r_valid;
  assign o_rdid        = r_rdid;
  assign o_rdwen       = r_rdwen;
  assign o_rdval       = r_rdval;
  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_illegal     = r_illegal;

endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;
  localparam int          XLEN      = 64;
  localparam logic [63:0] MTVEC_RST = 64'h1000;
  localparam logic [63:0] HARTID    = 64'h5;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready, i_ready;
  logic [2:0]  i_func3;
  logic [1:0]  i_sysop;
  logic [11:0] i_csrid;
  logic [4:0]  i_rs1id, i_rdid;
  logic [63:0] i_rs1val, i_pc;
  logic        o_valid, o_rdwen, o_redirect, o_illegal;
  logic [4:0]  o_rdid;
  logic [63:0] o_rdval, o_redirect_pc;

  csr_unit #(.XLEN(XLEN), .MTVEC_RST(MTVEC_RST), .HARTID(HARTID)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_func3(i_func3), .i_sysop(i_sysop), .i_csrid(i_csrid), .i_rs1id(i_rs1id),
    .i_rs1val(i_rs1val), .i_rdid(i_rdid), .i_pc(i_pc), .o_valid(o_valid),
    .i_ready(i_ready), .o_rdid(o_rdid), .o_rdwen(o_rdwen), .o_rdval(o_rdval),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  rdid;
    logic        rdwen;
    logic [63:0] rdval;
    logic        chk_val;
    logic        redirect;
    logic [63:0] rpc;
    logic        illegal;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  task automatic push(input string name, input logic [4:0] rdid, input logic rdwen,
                      input logic [63:0] rdval, input logic chk_val, input logic redirect,
                      input logic [63:0] rpc, input logic illegal);
    exp_t x;
    x.name = name; x.rdid = rdid; x.rdwen = rdwen; x.rdval = rdval; x.chk_val = chk_val;
    x.redirect = redirect; x.rpc = rpc; x.illegal = illegal;
    q.push_back(x);
  endtask

  // Drive one request at a negedge and hold it until the DUT takes it.
  task automatic send(input string name, input logic [2:0] f3, input logic [1:0] sysop,
                      input logic [11:0] csr, input logic [4:0] rs1, input logic [63:0] rs1v,
                      input logic [4:0] rd, input logic [63:0] pc);
    int n = 0;
    @(negedge clk);
    i_func3 = f3; i_sysop = sysop; i_csrid = csr; i_rs1id = rs1;
    i_rs1val = rs1v; i_rdid = rd; i_pc = pc; i_valid = 1'b1;
    #1;
    while (!o_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    n_chk++;
    if (o_ready) n_pass++;
    else $display("FAIL %s_accept: got o_ready=0 for 100 cycles want o_ready=1", name);
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic csr_op(input string name, input logic [2:0] f3, input logic [11:0] csr,
                        input logic [4:0] rs1, input logic [63:0] rs1v, input logic [4:0] rd,
                        input logic rdwen, input logic [63:0] rdval, input logic chk_val);
    push(name, rd, rdwen, rdval, chk_val, 1'b0, 64'h0, 1'b0);
    send(name, f3, 2'b01, csr, rs1, rs1v, rd, 64'h0);
  endtask

  task automatic ill_op(input string name, input logic [2:0] f3, input logic [1:0] sysop,
                        input logic [11:0] csr, input logic [4:0] rs1, input logic [4:0] rd);
    push(name, rd, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1);
    send(name, f3, sysop, csr, rs1, 64'h1, rd, 64'h0);
  endtask

  task automatic sys_op(input string name, input logic [1:0] sysop, input logic [63:0] pc,
                        input logic [63:0] rpc, input logic expect_out);
    if (expect_out) push(name, 5'd0, 1'b0, 64'h0, 1'b0, 1'b1, rpc, 1'b0);
    send(name, 3'b000, sysop, 12'h0, 5'd0, 64'h0, 5'd0, pc);
  endtask

  // Monitor: one comparison per transferred result, in issue order.
  always begin
    @(negedge clk); #1;
    if (!rst && o_valid && i_ready) begin
      n_chk++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_output: got rdid=%0d rdval=%h redirect=%b want no output",
                 o_rdid, o_rdval, o_redirect);
      end else begin
        e = q.pop_front();
        if (o_rdid === e.rdid && o_rdwen === e.rdwen && o_illegal === e.illegal &&
            o_redirect === e.redirect && (!e.redirect || o_redirect_pc === e.rpc) &&
            (!e.chk_val || o_rdval === e.rdval))
          n_pass++;
        else
          $display("FAIL %s: got rdid=%0d rdwen=%b rdval=%h redir=%b rpc=%h ill=%b want rdid=%0d rdwen=%b rdval=%h(chk %b) redir=%b rpc=%h ill=%b",
                   e.name, o_rdid, o_rdwen, o_rdval, o_redirect, o_redirect_pc, o_illegal,
                   e.rdid, e.rdwen, e.rdval, e.chk_val, e.redirect, e.rpc, e.illegal);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish within 400000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_func3 = 3'b0; i_sysop = 2'b0;
    i_csrid = 12'h0; i_rs1id = 5'd0; i_rs1val = 64'h0; i_rdid = 5'd0; i_pc = 64'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_o_valid", 64'(o_valid), 64'h0);
    check("rst_o_ready", 64'(o_ready), 64'h1);
    check("rst_o_rdval", o_rdval, 64'h0);
    check("rst_o_rdwen", 64'(o_rdwen), 64'h0);
    check("rst_o_rdid", 64'(o_rdid), 64'h0);
    check("rst_o_redirect", 64'(o_redirect), 64'h0);
    check("rst_o_redirect_pc", o_redirect_pc, 64'h0);
    check("rst_o_illegal", 64'(o_illegal), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    csr_op("mtvec_rst", 3'b010, 12'h305, 5'd0, 64'h0, 5'd1, 1'b1, 64'h1000, 1'b1);

    // Plain read/write and set-with-x0 (no write).
    csr_op("rw_mscratch", 3'b001, 12'h340, 5'd1, 64'hDEAD_BEEF, 5'd5, 1'b1, 64'h0, 1'b1);
    csr_op("rs_mscratch_x0", 3'b010, 12'h340, 5'd0, 64'h1234, 5'd6, 1'b1, 64'hDEAD_BEEF, 1'b1);
    csr_op("rs_mscratch_again", 3'b010, 12'h340, 5'd0, 64'h0, 5'd7, 1'b1, 64'hDEAD_BEEF, 1'b1);

    // mstatus field masking and immediate forms.
    csr_op("rsi_mstatus", 3'b110, 12'h300, 5'd8, 64'h0, 5'd8, 1'b1, 64'h1800, 1'b1);
    csr_op("rci_mstatus_rd0", 3'b111, 12'h300, 5'd8, 64'h0, 5'd0, 1'b0, 64'h1808, 1'b1);
    csr_op("rs_mstatus", 3'b010, 12'h300, 5'd0, 64'h0, 5'd9, 1'b1, 64'h1800, 1'b1);
    csr_op("rw_mstatus_ones", 3'b001, 12'h300, 5'd1, '1, 5'd10, 1'b1, 64'h1800, 1'b1);
    csr_op("rw_mstatus_zero", 3'b001, 12'h300, 5'd1, 64'h0, 5'd11, 1'b1, 64'h1888, 1'b1);
    csr_op("mstatus_cleared", 3'b010, 12'h300, 5'd0, 64'h0, 5'd12, 1'b1, 64'h1800, 1'b1);

    // Trap entry and return.
    csr_op("rw_mtvec_rd0", 3'b001, 12'h305, 5'd2, 64'h8000_0103, 5'd0, 1'b0, 64'h0, 1'b0);
    csr_op("rs_mtvec_aligned", 3'b010, 12'h305, 5'd0, 64'h0, 5'd12, 1'b1, 64'h8000_0100, 1'b1);
    csr_op("rsi_mie_on", 3'b110, 12'h300, 5'd8, 64'h0, 5'd0, 1'b0, 64'h1800, 1'b1);
    sys_op("ecall", 2'b01, 64'h8000_0040, 64'h8000_0100, 1'b1);
    @(negedge clk); #1 check("ecall_ready_c1", 64'(o_ready), 64'h0);
    @(negedge clk); #1 check("ecall_ready_c2", 64'(o_ready), 64'h0);
    @(negedge clk); #1 check("ecall_ready_c3", 64'(o_ready), 64'h1);
    csr_op("mepc_ecall", 3'b010, 12'h341, 5'd0, 64'h0, 5'd13, 1'b1, 64'h8000_0040, 1'b1);
    csr_op("mcause_ecall", 3'b010, 12'h342, 5'd0, 64'h0, 5'd14, 1'b1, 64'd11, 1'b1);
    csr_op("mstatus_trap", 3'b010, 12'h300, 5'd0, 64'h0, 5'd15, 1'b1, 64'h1880, 1'b1);
    sys_op("mret", 2'b11, 64'h8000_0104, 64'h8000_0040, 1'b1);
    csr_op("mstatus_mret", 3'b010, 12'h300, 5'd0, 64'h0, 5'd16, 1'b1, 64'h1888, 1'b1);
    sys_op("ebreak", 2'b10, 64'h8000_0080, 64'h8000_0100, 1'b1);
    csr_op("mcause_ebreak", 3'b010, 12'h342, 5'd0, 64'h0, 5'd14, 1'b1, 64'd3, 1'b1);
    csr_op("mstatus_ebreak", 3'b010, 12'h300, 5'd0, 64'h0, 5'd15, 1'b1, 64'h1880, 1'b1);

    // Illegal accesses and read-only space.
    ill_op("rw_mhartid", 3'b001, 2'b01, 12'hF14, 5'd1, 5'd17);
    ill_op("rs_unmapped", 3'b010, 2'b01, 12'h7C0, 5'd1, 5'd18);
    csr_op("rs_mhartid_x0", 3'b010, 12'hF14, 5'd0, 64'h0, 5'd0, 1'b0, 64'h5, 1'b1);
    csr_op("rs_mhartid_rd", 3'b010, 12'hF14, 5'd0, 64'h0, 5'd19, 1'b1, 64'h5, 1'b1);
    ill_op("func3_100", 3'b100, 2'b01, 12'h300, 5'd1, 5'd3);
    ill_op("sysop_00", 3'b000, 2'b00, 12'h000, 5'd0, 5'd4);
    csr_op("rw_mepc_misaligned", 3'b001, 12'h341, 5'd1, 64'h1237, 5'd20, 1'b1, 64'h8000_0080, 1'b1);
    csr_op("rs_mepc_aligned", 3'b010, 12'h341, 5'd0, 64'h0, 5'd21, 1'b1, 64'h1234, 1'b1);
    csr_op("mstatus_after_ill", 3'b010, 12'h300, 5'd0, 64'h0, 5'd22, 1'b1, 64'h1880, 1'b1);

    // Backpressure: hold the result 3 cycles with a second request waiting.
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    csr_op("bp_first", 3'b010, 12'h340, 5'd0, 64'h0, 5'd23, 1'b1, 64'hDEAD_BEEF, 1'b1);
    push("bp_second", 5'd24, 1'b1, 64'hDEAD_BEEF, 1'b1, 1'b0, 64'h0, 1'b0);
    i_func3 = 3'b001; i_sysop = 2'b01; i_csrid = 12'h340; i_rs1id = 5'd3;
    i_rs1val = 64'h55; i_rdid = 5'd24; i_pc = 64'h0; i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check("bp_o_valid", 64'(o_valid), 64'h1);
      check("bp_o_rdval", o_rdval, 64'hDEAD_BEEF);
      check("bp_o_rdid", 64'(o_rdid), 64'd23);
      check("bp_o_ready", 64'(o_ready), 64'h0);
    end
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    csr_op("bp_single_write", 3'b010, 12'h340, 5'd0, 64'h0, 5'd25, 1'b1, 64'h55, 1'b1);

    // mcycle write takes precedence, then wraps on the next increment.
    csr_op("rw_mcycle_ones", 3'b001, 12'hB00, 5'd1, '1, 5'd26, 1'b1, 64'h0, 1'b0);
    @(posedge clk);
    csr_op("mcycle_wrapped", 3'b010, 12'hB00, 5'd0, 64'h0, 5'd27, 1'b1, 64'h0, 1'b1);

    // Reset in the middle of a trap.
    sys_op("ecall_aborted", 2'b01, 64'h8000_0200, 64'h0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_o_valid", 64'(o_valid), 64'h0);
    check("midrst_o_ready", 64'(o_ready), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    csr_op("mepc_after_rst", 3'b010, 12'h341, 5'd0, 64'h0, 5'd28, 1'b1, 64'h0, 1'b1);
    csr_op("mscratch_after_rst", 3'b010, 12'h340, 5'd0, 64'h0, 5'd29, 1'b1, 64'h0, 1'b1);
    sys_op("ecall_after_rst", 2'b01, 64'h8000_0300, 64'h1000, 1'b1);
    csr_op("mepc_ecall2", 3'b010, 12'h341, 5'd0, 64'h0, 5'd30, 1'b1, 64'h8000_0300, 1'b1);
    csr_op("mcause_ecall2", 3'b010, 12'h342, 5'd0, 64'h0, 5'd31, 1'b1, 64'd11, 1'b1);
    csr_op("mstatus_ecall2", 3'b010, 12'h300, 5'd0, 64'h0, 5'd1, 1'b1, 64'h1800, 1'b1);

    repeat (4) @(negedge clk);
    #2;
    check("scoreboard_drained", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
